// File: rtl/cim_read_ctrl.sv
// cim_read_ctrl: sequences a burst of row reads from a compute-in-memory array.
// A burst starts in IDLE on start. Rows 0..last_addr are read in order. Each row is
// driven on cim_a with read held high. After a settle period the row's q_in is captured
// into dout, which is then offered downstream with a valid/ready handshake. Every output
// is a register.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             burst request (sampled in IDLE only)
//   last_addr[3:0]    final row of the burst, captured when start is accepted
//   q_in[15:0]        array readout for the current cim_a
//   read              read-mode select to the IO decoder
//   cim_a[3:0]        row address being read
//   dout[15:0]        captured readout word
//   dout_valid        dout holds an untransferred word
//   dout_ready        downstream accepts dout
//   busy              high in every state except IDLE
//   done              one-cycle pulse when a burst completes
//   dout_par          XOR of the captured word (only with CIM_READ_PARITY_EN defined)
//
// Parameter SETTLE_CYC (1..15) sets the settle counter reload value.
module cim_read_ctrl #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  last_addr,
    input  logic [15:0] q_in,
    output logic        read,
    output logic [3:0]  cim_a,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        busy,
    output logic        done
`ifdef CIM_READ_PARITY_EN
    ,
    output logic        dout_par
`endif
);

    typedef enum logic [2:0] {StIdle, StSettle, StCapt, StSend, StDone} state_e;

    localparam logic [3:0] SettleLd = 4'(SETTLE_CYC);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  last_q, last_d;
    logic        read_q, read_d;
    logic [3:0]  cim_a_q, cim_a_d;
    logic [15:0] dout_q, dout_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        par_q, par_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        read_d  = read_q;
        cim_a_d = cim_a_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        par_d   = par_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    last_d  = last_addr;
                    cim_a_d = 4'd0;
                    read_d  = 1'b1;
                    cnt_d   = SettleLd;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                // Counter runs down to zero; together with CAPT this gives the
                // SETTLE_CYC+2 edge spacing from accept/transfer to dout_valid.
                if (cnt_q == 4'd0) begin
                    state_d = StCapt;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCapt: begin
                dout_d  = q_in;
                par_d   = ^q_in;
                valid_d = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (dout_ready) begin
                    valid_d = 1'b0;
                    if (cim_a_q == last_q) begin
                        read_d  = 1'b0;
                        cim_a_d = 4'd0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        cim_a_d = cim_a_q + 4'd1;
                        cnt_d   = SettleLd;
                        state_d = StSettle;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                read_d  = 1'b0;
                cim_a_d = 4'd0;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            last_q  <= 4'd0;
            read_q  <= 1'b0;
            cim_a_q <= 4'd0;
            dout_q  <= 16'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            read_q  <= read_d;
            cim_a_q <= cim_a_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            par_q   <= par_d;
        end
    end

    assign read       = read_q;
    assign cim_a      = cim_a_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef CIM_READ_PARITY_EN
    assign dout_par = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_cim_read_ctrl.sv
module tb_cim_read_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Instance A: SETTLE_CYC = 1
    logic        start_a = 1'b0;
    logic [3:0]  last_a = 4'd0;
    logic [15:0] q_a;
    logic        read_a, valid_a, busy_a, done_a;
    logic        ready_a = 1'b1;
    logic [3:0]  cim_a_a;
    logic [15:0] dout_a;

    // Instance B: SETTLE_CYC = 4
    logic        start_b = 1'b0;
    logic [3:0]  last_b = 4'd0;
    logic [15:0] q_b;
    logic        read_b, valid_b, busy_b, done_b;
    logic        ready_b = 1'b1;
    logic [3:0]  cim_a_b;
    logic [15:0] dout_b;

    // Array model: row r reads 16'hA000+r (A) / 16'h5A00+r (B), unless overridden.
    logic        q_mode = 1'b0;
    logic [15:0] q_ovr = 16'd0;
    assign q_a = q_mode ? q_ovr : (16'hA000 + {12'd0, cim_a_a});
    assign q_b = 16'h5A00 + {12'd0, cim_a_b};

    int tests = 0;
    int fails = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

`ifdef CIM_READ_PARITY_EN
    logic par_a, par_b;
`endif

    cim_read_ctrl #(.SETTLE_CYC(1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .last_addr  (last_a),
        .q_in       (q_a),
        .read       (read_a),
        .cim_a      (cim_a_a),
        .dout       (dout_a),
        .dout_valid (valid_a),
        .dout_ready (ready_a),
        .busy       (busy_a),
        .done       (done_a)
`ifdef CIM_READ_PARITY_EN
        ,
        .dout_par   (par_a)
`endif
    );

    cim_read_ctrl #(.SETTLE_CYC(4)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .last_addr  (last_b),
        .q_in       (q_b),
        .read       (read_b),
        .cim_a      (cim_a_b),
        .dout       (dout_b),
        .dout_valid (valid_b),
        .dout_ready (ready_b),
        .busy       (busy_b),
        .done       (done_b)
`ifdef CIM_READ_PARITY_EN
        ,
        .dout_par   (par_b)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for dout_valid, then check latency, word, row and read.
    task automatic wait_word(input string tag, input logic use_b, input logic [15:0] exp,
                             input logic [3:0] row, input int lat);
        int n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (use_b ? valid_b : valid_a) begin
                n = i;
                break;
            end
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_dout"}, use_b ? dout_b : dout_a, exp);
        chk({tag, "_row"}, use_b ? cim_a_b : cim_a_a, row);
        chk({tag, "_read"}, use_b ? read_b : read_a, 1'b1);
    endtask

    initial begin
        int d0;

        // Reset state (asynchronous: visible before any clock edge)
        #1;
        chk("rst_outs", {read_a, cim_a_a, dout_a, valid_a, busy_a, done_a}, 0);
        chk("rst_outs_b", {read_b, cim_a_b, dout_b, valid_b, busy_b, done_b}, 0);
        tick();
        tick();

        // Basic burst rows 0..3; start accepted on first edge after reset release
        rst = 1'b0;
        last_a = 4'd3;
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("acc_state", {busy_a, read_a, cim_a_a, valid_a}, {1'b1, 1'b1, 4'd0, 1'b0});
        d0 = done_cnt_a;
        for (int w = 0; w < 4; w++) begin
            wait_word($sformatf("b1_w%0d", w), 1'b0, 16'hA000 + 16'(w), 4'(w), 3);
            tick();
            if (w < 3) chk($sformatf("b1_vdrop%0d", w), valid_a, 1'b0);
        end
        chk("b1_done", {done_a, read_a, cim_a_a, valid_a, busy_a},
            {1'b1, 1'b0, 4'd0, 1'b0, 1'b1});
        tick();
        chk("b1_idle", {done_a, busy_a}, 2'b00);
        chk("b1_done_cnt", done_cnt_a - d0, 1);

        // Stall at row 2, plus start re-pulse and last_addr change mid-burst
        last_a = 4'd4;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_word("b2_w0", 1'b0, 16'hA000, 4'd0, 3);
        tick();
        wait_word("b2_w1", 1'b0, 16'hA001, 4'd1, 3);
        start_a = 1'b1;
        last_a = 4'd1;
        tick();
        start_a = 1'b0;
        wait_word("b2_w2", 1'b0, 16'hA002, 4'd2, 3);
        ready_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("stall%0d", i), {valid_a, read_a, cim_a_a, dout_a},
                {1'b1, 1'b1, 4'd2, 16'hA002});
        end
        ready_a = 1'b1;
        tick();
        wait_word("b2_w3", 1'b0, 16'hA003, 4'd3, 3);
        tick();
        wait_word("b2_w4", 1'b0, 16'hA004, 4'd4, 3);
        tick();
        chk("b2_done", done_a, 1'b1);
        tick();

        // Abort a last_addr=15 burst at row 5 with an asynchronous reset
        last_a = 4'd15;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int w = 0; w < 5; w++) begin
            wait_word($sformatf("b3_w%0d", w), 1'b0, 16'hA000 + 16'(w), 4'(w), 3);
            tick();
        end
        chk("b3_row5", cim_a_a, 4'd5);
        d0 = done_cnt_a;
        #2;
        rst = 1'b1;
        #1;
        chk("abort_outs", {read_a, cim_a_a, dout_a, valid_a, busy_a, done_a}, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_idle", {busy_a, read_a, valid_a}, 0);
        chk("abort_nodone", done_cnt_a - d0, 0);
        last_a = 4'd0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_word("b3_new", 1'b0, 16'hA000, 4'd0, 3);
        tick();
        chk("b3_new_done", done_a, 1'b1);
        tick();

        // SETTLE_CYC=4, last_addr=0: one word, valid after 6 edges
        d0 = done_cnt_b;
        last_b = 4'd0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_word("b4_w0", 1'b1, 16'h5A00, 4'd0, 6);
        tick();
        chk("b4_done", {done_b, valid_b, read_b}, 3'b100);
        tick();
        chk("b4_idle", {done_b, busy_b}, 2'b00);
        for (int i = 0; i < 8; i++) tick();
        chk("b4_one_word", {valid_b, busy_b}, 2'b00);
        chk("b4_done_cnt", done_cnt_b - d0, 1);

`ifdef CIM_READ_PARITY_EN
        // Parity of captured words
        q_mode = 1'b1;
        q_ovr = 16'h0001;
        last_a = 4'd1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_word("par_w0", 1'b0, 16'h0001, 4'd0, 3);
        chk("par_1", par_a, 1'b1);
        q_ovr = 16'h0003;
        tick();
        wait_word("par_w1", 1'b0, 16'h0003, 4'd1, 3);
        chk("par_0", par_a, 1'b0);
        tick();
        tick();
        q_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
